sink_in_16bit: RTL and testbench
================================

# sink_in_16bit

Receive-side capture block for the 16-bit source stream, the counterpart of the source output stage. Samples `data_in` on every rising `clk` edge where `data_en_in` is high. Buffers the words in a small synchronous FIFO and hands them downstream over a valid/ready handshake. Tracks burst boundaries (runs of `data_en_in` high) and reports burst length and overflow for the SSD control logic.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO depth in words; power of two, 2..256.
- `AW`, default 4: log2(`DEPTH`).

Ports:
- `clk` in 1: system clock, all logic on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `data_en_in` in 1: word-valid strobe from the source; no backpressure toward the source.
- `data_in` in 16: word from the source, sampled when `data_en_in`=1.
- `out_valid` out 1: FIFO holds at least one word.
- `out_data` out 16: head-of-FIFO word; valid when `out_valid`=1.
- `out_ready` in 1: downstream accepts. Pop occurs when `out_valid & out_ready`.
- `level` out AW+1: current FIFO occupancy, 0..`DEPTH`.
- `burst_done` out 1: one-cycle pulse at the end of a burst.
- `burst_len` out 16: words received in the last completed burst; held until the next `burst_done`.
- `overflow` out 1: sticky; set when a word is dropped.
- `clr_ovf` in 1: synchronous clear of `overflow`.

## Operation
- Write: at a rising edge with `data_en_in`=1, `data_in` is written at `wr_ptr`. The word is accepted only if `level` < `DEPTH`, or if a pop happens in the same cycle.
- Full with no pop: the word is dropped and `overflow` is set. Pointers and `level` are unchanged.
- Full with a simultaneous pop: the word is accepted and `level` stays at `DEPTH`.
- Empty with a simultaneous write: no pop occurs, because `out_valid`=0. `level` becomes 1.
- Read is show-ahead: `out_data` = mem[`rd_ptr`] (combinational from the registered pointer). `out_valid` = (`level`≠0). A pop advances `rd_ptr`.
- Pointers are AW bits and wrap modulo `DEPTH`. `level` is a separate AW+1-bit counter: +1 on write only, −1 on pop only, unchanged on both or neither.
- `overflow`:
  - A set event and `clr_ovf` in the same cycle leave it set (set wins).
  - Otherwise `clr_ovf`=1 clears it.
- Burst tracker:
  - Registered `en_d` = previous `data_en_in`.
  - `burst_cnt` (16 bit) increments on every cycle with `data_en_in`=1, counting dropped words too. It saturates at 16'hFFFF.
  - When `en_d`=1 and `data_en_in`=0: `burst_len` ← `burst_cnt`, `burst_done` ← 1 for one cycle, `burst_cnt` ← 0.
- States of the burst tracker: IDLE (`en_d`=0) and ACTIVE (`en_d`=1).
  - IDLE→ACTIVE on `data_en_in`=1.
  - ACTIVE→IDLE on `data_en_in`=0, which fires `burst_done`.
- Reset (asynchronous, any time, including mid-burst or with the FIFO non-empty):
  - Pointers, `level`, `en_d`, `burst_cnt`, `burst_len`, `burst_done` and `overflow` all go to 0.
  - `out_valid`=0.
  - FIFO contents are don't-care; `out_data` is X-tolerant while `out_valid`=0.
  - The partial burst is discarded and no `burst_done` is produced.

## Timing
- Write-to-output latency is 1 edge: a word written at edge N gives `out_valid`=1 and `level`=1 after edge N.
- Pop: after the edge where `out_valid & out_ready`, `out_data` shows the next word.
- Sustained throughput is 1 word/cycle in and 1 word/cycle out.
- `burst_done` rises after the first edge sampling `data_en_in`=0 following a burst. It lasts exactly 1 cycle. `burst_len` is updated on the same edge.
- The last word of a burst is in the FIFO no later than `burst_done`.
- A single-cycle gap in `data_en_in` ends one burst and the next burst starts on the following cycle. Back-to-back bursts are each reported.

## Structure
- Shared package `ssd_pkg`: `DATA_W`=16, the default `DEPTH`/`AW`, and the `burst_len` width constant.
- One sub-module, `sink_fifo_sync`: a parameterized single-clock show-ahead FIFO with push/pop, full/empty and level.
- The top level holds only the accept/drop decision, the burst tracker and the `overflow` flag.

## Test plan
- Reset, then a 5-word burst 16'h0001..16'h0005 with `out_ready`=0:
  - `level`=5 and `out_data`=16'h0001.
  - `burst_done` pulses once with `burst_len`=5.
  - Draining with `out_ready`=1 yields 1..5 in order, then `out_valid`=0.
- 20-word burst with DEPTH=16 and `out_ready`=0:
  - Words 1..16 are stored and words 17..20 are dropped.
  - `overflow`=1, `burst_len`=20.
  - Pulse `clr_ovf` → `overflow`=0.
- FIFO full with `data_en_in`=1 and `out_ready`=1 for 10 cycles:
  - No drop, `level` stays at 16, `overflow` stays 0.
  - Output order is preserved across pointer wrap.
- Bursts of 3, a 1-cycle gap, then 4: two `burst_done` pulses with `burst_len`=3 then 4, and 7 words delivered in order.
- `nRST` asserted mid-burst with `level`=6:
  - All outputs go to 0 immediately, with no `burst_done`.
  - After release, a 2-word burst reports `burst_len`=2.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and types for the SSD source/sink stream blocks.
package ssd_pkg;

    localparam int DATA_W    = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;
    localparam int BLEN_W    = 16;

    typedef enum logic {
        BURST_IDLE   = 1'b0,
        BURST_ACTIVE = 1'b1
    } burst_state_e;

    // Saturating increment so very long bursts report 16'hFFFF rather than wrapping.
    function automatic logic [BLEN_W-1:0] sat_inc(input logic [BLEN_W-1:0] v);
        return (v == {BLEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sink_fifo_sync.sv
// Single-clock show-ahead FIFO: head word is visible on rd_data while not empty.
module sink_fifo_sync
    import ssd_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int W     = DATA_W
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    // A push into a full FIFO is only legal when the same cycle pops.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sink_in_16bit.sv
// Receive-side capture of the 16-bit source stream: FIFO buffering with drop
// detection, plus burst-length reporting for the SSD control logic.
module sink_in_16bit
    import ssd_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              data_en_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [AW:0]       level,
    output logic              burst_done,
    output logic [BLEN_W-1:0] burst_len,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic fifo_full, fifo_empty;
    logic push, pop, drop;

    burst_state_e      state_q, state_d;
    logic [BLEN_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BLEN_W-1:0] burst_len_q, burst_len_d;
    logic              burst_done_q, burst_done_d;
    logic              overflow_q, overflow_d;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = data_en_in & (~fifo_full | pop);
    assign drop      = data_en_in & fifo_full & ~pop;

    sink_fifo_sync #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Set wins over clear so a drop in the clearing cycle is never lost.
    assign overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);

    // The state register doubles as the delayed strobe en_d.
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        burst_len_d  = burst_len_q;
        burst_done_d = 1'b0;
        case (state_q)
            BURST_IDLE: begin
                if (data_en_in) begin
                    state_d     = BURST_ACTIVE;
                    burst_cnt_d = sat_inc(burst_cnt_q);
                end
            end
            BURST_ACTIVE: begin
                if (data_en_in) begin
                    burst_cnt_d = sat_inc(burst_cnt_q);
                end else begin
                    state_d      = BURST_IDLE;
                    burst_len_d  = burst_cnt_q;
                    burst_done_d = 1'b1;
                    burst_cnt_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= BURST_IDLE;
            burst_cnt_q  <= '0;
            burst_len_q  <= '0;
            burst_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_len_q  <= burst_len_d;
            burst_done_q <= burst_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign burst_done = burst_done_q;
    assign burst_len  = burst_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sink_in_16bit.sv
// Bench for sink_in_16bit: directed scenarios plus random traffic checked
// against a queue-based behavioural model.
module tb_sink_in_16bit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        nRST;
    logic        data_en_in;
    logic [15:0] data_in;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [AW:0] level;
    logic        burst_done;
    logic [15:0] burst_len;
    logic        overflow;
    logic        clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_en_d;
    logic        m_done;
    logic [15:0] m_cnt;
    logic [15:0] m_len;

    sink_in_16bit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .data_en_in (data_en_in),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .burst_done (burst_done),
        .burst_len  (burst_len),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_en_d = 1'b0;
        m_done = 1'b0;
        m_cnt  = '0;
        m_len  = '0;
    endtask

    // Drive one cycle of inputs, advance the model, and return 1ns after the edge.
    task automatic step(input logic en, input logic [15:0] d, input logic rdy, input logic clr);
        bit pop, full, push, drop;
        data_en_in = en;
        data_in    = d;
        out_ready  = rdy;
        clr_ovf    = clr;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        push = en && (!full || pop);
        drop = en && full && !pop;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_done = m_en_d && !en;
        if (m_done) begin
            m_len = m_cnt;
            m_cnt = '0;
        end else if (en && m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
        end
        m_en_d = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; data_en_in = 1'b0; data_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || level !== '0 || burst_done !== 1'b0 || burst_len !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b level=%0d done=%b len=%0d ovf=%b, required all 0",
                     out_valid, level, burst_done, burst_len, overflow);
        end
        nRST = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd5 || out_data !== 16'h0001 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fill: level=%0d data=%h valid=%b, required 5/0001/1", level, out_data, out_valid);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (burst_done !== 1'b1 || burst_len !== 16'd5) begin
            n_fail++;
            $display("FAIL basic_burst: done=%b len=%0d, required 1/5", burst_done, burst_len);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (burst_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: done=%b, required 0", burst_done);
        end
        for (int i = 1; i <= 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL basic_drain: valid=%b data=%h, required 1/%h", out_valid, out_data, 16'(i));
            end
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL basic_empty: valid=%b level=%0d, required 0/0", out_valid, level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 20; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || out_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL ovf_fill: level=%0d ovf=%b head=%h, required 16/1/0001", level, overflow, out_data);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (burst_done !== 1'b1 || burst_len !== 16'd20) begin
            n_fail++;
            $display("FAIL ovf_burst: done=%b len=%0d, required 1/20", burst_done, burst_len);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b level=%0d, required 0/16", overflow, level);
        end
    endtask

    // FIFO starts full (1..16); write and pop together so pointers wrap with no drop.
    task automatic test_full_passthrough();
        logic [15:0] exp;
        for (int i = 0; i < 10; i++) begin
            exp = mq[0];
            n_checks++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL pass_head: data=%h, required %h", out_data, exp);
            end
            step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            n_checks++;
            if (level !== 5'd16 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL pass_level: level=%0d ovf=%b, required 16/0", level, overflow);
            end
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = mq[0];
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++;
                $display("FAIL pass_drain: valid=%b data=%h, required 1/%h", out_valid, out_data, exp);
            end
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_words [7];
        logic [15:0] lens [$];
        exp_words = '{16'h0200, 16'h0201, 16'h0202, 16'h0300, 16'h0301, 16'h0302, 16'h0303};
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        if (burst_done === 1'b1) lens.push_back(burst_len);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
            if (burst_done === 1'b1) lens.push_back(burst_len);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        if (burst_done === 1'b1) lens.push_back(burst_len);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        if (burst_done === 1'b1) lens.push_back(burst_len);
        n_checks++;
        if (lens.size() != 2 || lens[0] !== 16'd3 || lens[1] !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_pulses: count=%0d, required 2 pulses with len 3 then 4", lens.size());
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
                n_fail++;
                $display("FAIL b2b_order: valid=%b data=%h, required 1/%h", out_valid, out_data, exp_words[i]);
            end
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        logic en, rdy, clr;
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 19) == 0);
            step(en, 16'($urandom), rdy, clr);
            n_checks++;
            if (out_valid !== (mq.size() != 0) || level !== (AW+1)'(mq.size()) ||
                (mq.size() != 0 && out_data !== mq[0]) || overflow !== m_ovf ||
                burst_done !== m_done || burst_len !== m_len) begin
                n_fail++;
                $display("FAIL random_cycle%0d: valid=%b level=%0d data=%h ovf=%b done=%b len=%0d, required level=%0d head=%h ovf=%b done=%b len=%0d",
                         c, out_valid, level, out_data, overflow, burst_done, burst_len,
                         mq.size(), (mq.size() != 0) ? mq[0] : 16'h0, m_ovf, m_done, m_len);
            end
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int c = 0; c < 2 * DEPTH && mq.size() != 0; c++) step(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        // Leave overflow set going in so reset clearing it is observable.
        for (int i = 0; i < 17; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd6 || overflow !== 1'b1 || burst_len !== 16'd17) begin
            n_fail++;
            $display("FAIL mid_pre: level=%0d ovf=%b len=%0d, required 6/1/17", level, overflow, burst_len);
        end
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 1'b0 || level !== '0 || burst_done !== 1'b0 || burst_len !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b level=%0d done=%b len=%0d ovf=%b, required all 0",
                     out_valid, level, burst_done, burst_len, overflow);
        end
        data_en_in = 1'b0;
        #1;
        nRST = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (burst_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_done: done=%b, required 0", burst_done);
        end
        step(1'b1, 16'h0600, 1'b0, 1'b0);
        step(1'b1, 16'h0601, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (burst_done !== 1'b1 || burst_len !== 16'd2 || level !== 5'd2 || out_data !== 16'h0600) begin
            n_fail++;
            $display("FAIL mid_after: done=%b len=%0d level=%0d head=%h, required 1/2/2/0600",
                     burst_done, burst_len, level, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_passthrough();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
